// File: rtl/mips32_test_sequencer_if.sv
// Bus between the self-check sequencer and the test table, the core memory
// and the core run/halt controls.
interface mips32_test_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int IDX_W  = 5
);
  logic [IDX_W-1:0]  tbl_idx;
  logic [ADDR_W-1:0] tbl_addr;
  logic [DATA_W-1:0] tbl_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              core_run;
  logic              core_halted;

  modport master (
    output tbl_idx, mem_we, mem_addr, mem_wdata, core_run,
    input  tbl_addr, tbl_data, mem_rdata, core_halted
  );

  modport slave (
    input  tbl_idx, mem_we, mem_addr, mem_wdata, core_run,
    output tbl_addr, tbl_data, mem_rdata, core_halted
  );
endinterface

// File: rtl/mips32_test_sequencer.sv
// Self-check harness for pipe_MIPS32: preload program and data from a table,
// run the core until HALTED or timeout, then compare check addresses.
module mips32_test_sequencer #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int PROG_DEPTH  = 8,
  parameter int INIT_DEPTH  = 1,
  parameter int CHECK_DEPTH = 2,
  parameter int TIMEOUT     = 1000,
  parameter int IDX_W       = 5
) (
  input  logic                   clk1,
  input  logic                   reset,
  input  logic                   start,
  mips32_test_sequencer_if.master bus,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout_err,
  output logic [IDX_W-1:0]       fail_idx
);

  localparam int LOAD_LAST = PROG_DEPTH + INIT_DEPTH - 1;
  localparam int CHK_FIRST = PROG_DEPTH + INIT_DEPTH;
  localparam int CHK_LAST  = PROG_DEPTH + INIT_DEPTH + CHECK_DEPTH - 1;
  localparam int CNT_W     = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_CHECK_RD, S_CHECK_CMP, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  tbl_idx_q, tbl_idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic [IDX_W-1:0]  fail_idx_q, fail_idx_d;

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tbl_idx_q  <= '0;
      cnt_q      <= '0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      fail_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      tbl_idx_q  <= tbl_idx_d;
      cnt_q      <= cnt_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  // Bus outputs are decoded from state so an asynchronous reset drops them at once.
  always_comb begin
    state_d       = state_q;
    tbl_idx_d     = tbl_idx_q;
    cnt_d         = cnt_q;
    pass_d        = pass_q;
    timeout_d     = timeout_q;
    fail_idx_d    = fail_idx_q;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.core_run  = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
          fail_idx_d = '0;
          tbl_idx_d  = '0;
          state_d    = S_LOAD;
        end
      end

      S_LOAD: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = bus.tbl_addr;
        bus.mem_wdata = bus.tbl_data;
        if (tbl_idx_q == IDX_W'(LOAD_LAST)) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          tbl_idx_d = tbl_idx_q + 1'b1;
        end
      end

      S_RUN: begin
        bus.core_run = 1'b1;
        // The halt flag may still be stale from a previous run on cycle 0.
        if (cnt_q != '0 && bus.core_halted) begin
          if (CHECK_DEPTH == 0) begin
            pass_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            tbl_idx_d = IDX_W'(CHK_FIRST);
            state_d   = S_CHECK_RD;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_CHECK_RD: begin
        bus.mem_addr = bus.tbl_addr;
        state_d      = S_CHECK_CMP;
      end

      S_CHECK_CMP: begin
        bus.mem_addr = bus.tbl_addr;
        if (bus.mem_rdata != bus.tbl_data) begin
          fail_idx_d = tbl_idx_q;
          pass_d     = 1'b0;
          state_d    = S_DONE;
        end else if (tbl_idx_q == IDX_W'(CHK_LAST)) begin
          pass_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          tbl_idx_d = tbl_idx_q + 1'b1;
          state_d   = S_CHECK_RD;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.tbl_idx = tbl_idx_q;
  assign busy        = (state_q == S_LOAD) || (state_q == S_RUN) ||
                       (state_q == S_CHECK_RD) || (state_q == S_CHECK_CMP);
  assign done        = (state_q == S_DONE);
  assign pass        = pass_q;
  assign timeout_err = timeout_q;
  assign fail_idx    = fail_idx_q;

endmodule

// File: tb/tb_mips32_test_sequencer.sv
// Randomized bench: fake core + memory, reference model predicts latency and verdict.
module tb_mips32_test_sequencer;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 10;
  localparam int IDX_W   = 5;
  localparam int TIMEOUT = 50;
  localparam int NENT    = 11;
  localparam int NLOAD   = 9;

  logic clk1 = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, done, pass, timeout_err;
  logic [IDX_W-1:0] fail_idx;

  always #5 clk1 = ~clk1;

  mips32_test_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) bus ();

  mips32_test_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PROG_DEPTH(8), .INIT_DEPTH(1),
    .CHECK_DEPTH(2), .TIMEOUT(TIMEOUT), .IDX_W(IDX_W)
  ) dut (
    .clk1(clk1), .reset(reset), .start(start), .bus(bus),
    .busy(busy), .done(done), .pass(pass), .timeout_err(timeout_err), .fail_idx(fail_idx)
  );

  // Test table
  logic [ADDR_W-1:0] tbl_a [NENT];
  logic [DATA_W-1:0] tbl_d [NENT];
  assign bus.tbl_addr = (int'(bus.tbl_idx) < NENT) ? tbl_a[bus.tbl_idx] : '0;
  assign bus.tbl_data = (int'(bus.tbl_idx) < NENT) ? tbl_d[bus.tbl_idx] : '0;

  // Core memory with registered read, plus a fake core that computes Mem[121]=Mem[120]+45 on halt
  logic [DATA_W-1:0] mem [1024];
  logic [DATA_W-1:0] rdata_q = '0;
  int   run_cnt = 0;
  int   halt_at = 1000;
  bit   stale_halt = 1'b0;
  logic halted_q = 1'b0;
  assign bus.mem_rdata   = rdata_q;
  assign bus.core_halted = halted_q;

  always @(posedge clk1) begin
    rdata_q <= mem[bus.mem_addr];
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.core_run) begin
      run_cnt  <= run_cnt + 1;
      halted_q <= (run_cnt + 1 >= halt_at);
      if (run_cnt + 1 == halt_at) mem[121] <= mem[120] + 32'd45;
    end else begin
      run_cnt  <= 0;
      halted_q <= stale_halt;
    end
  end

  // Write monitor and invariant watch
  logic [ADDR_W-1:0] wq_a [$];
  logic [DATA_W-1:0] wq_d [$];
  int viol = 0;
  always @(negedge clk1) begin
    if (bus.mem_we) begin
      wq_a.push_back(bus.mem_addr);
      wq_d.push_back(bus.mem_wdata);
    end
    if (bus.mem_we && (!busy || bus.core_run)) viol++;
    if (bus.core_run && !busy) viol++;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int run_no  = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic setup_table(input logic [DATA_W-1:0] init, input bit bad0, input bit bad1,
                             input bit no_hlt);
    logic [DATA_W-1:0] prog [8];
    prog[0] = 32'h2801_0078;  // ADDI R1,R0,120
    prog[1] = 32'h0ce7_7800;  // OR
    prog[2] = 32'h2022_0000;  // LW R2,0(R1)
    prog[3] = 32'h0ce7_7800;
    prog[4] = 32'h2842_002d;  // ADDI R2,R2,45
    prog[5] = 32'h0ce7_7800;
    prog[6] = 32'h2422_0001;  // SW R2,1(R1)
    prog[7] = no_hlt ? 32'h0ce7_7800 : 32'hfc00_0000;
    for (int i = 0; i < 8; i++) begin
      tbl_a[i] = ADDR_W'(i);
      tbl_d[i] = prog[i];
    end
    tbl_a[8]  = 10'd120; tbl_d[8]  = init;
    tbl_a[9]  = 10'd120; tbl_d[9]  = bad0 ? (init ^ 32'h1) : init;
    tbl_a[10] = 10'd121; tbl_d[10] = init + (bad1 ? 32'd46 : 32'd45);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_flags"}, {busy, done, pass, timeout_err, bus.mem_we, bus.core_run}, '0);
    check_val({tag, "_idx"}, {bus.tbl_idx, fail_idx}, '0);
    check_val({tag, "_mem"}, {bus.mem_addr, bus.mem_wdata}, '0);
  endtask

  // One start-to-done transaction, checked against the table-level model.
  task automatic run_seq(input int h, input bit stale, input int poke_n);
    bit halts, ok0, ok1, exp_pass;
    int runlen, nchk, lat, n;
    logic [IDX_W-1:0] exp_fidx;
    halt_at    = h;
    stale_halt = stale;
    halts  = (h >= 1) && (h <= TIMEOUT - 1);
    runlen = halts ? h + 1 : TIMEOUT;
    ok0    = (tbl_d[9]  == tbl_d[8]);
    ok1    = (tbl_d[10] == tbl_d[8] + 32'd45);
    nchk   = !halts ? 0 : (ok0 ? 2 : 1);
    exp_pass = halts && ok0 && ok1;
    exp_fidx = (!halts || exp_pass) ? '0 : (ok0 ? IDX_W'(10) : IDX_W'(9));
    lat = 10 + runlen + 2 * nchk;

    repeat (2) @(negedge clk1);
    wq_a.delete(); wq_d.delete();
    start = 1'b1;
    @(negedge clk1);
    start = 1'b0;
    n = 1;
    check_val("clear_on_start", {done, pass, timeout_err, fail_idx}, '0);
    while (!done && n < 400) begin
      start = (n == poke_n);
      @(negedge clk1);
      n++;
    end
    start = 1'b0;
    run_no++;
    $display("[TB] run %0d: halt_at=%0d stale=%0d poke=%0d latency=%0d pass=%0d to=%0d fidx=%0d",
             run_no, h, stale, poke_n, n, pass, timeout_err, fail_idx);
    check_val("latency", n, lat);
    check_val("done_busy", {done, busy, bus.core_run}, 3'b100);
    check_val("pass", pass, exp_pass);
    check_val("timeout_err", timeout_err, !halts);
    check_val("fail_idx", fail_idx, exp_fidx);
    check_val("we_count", wq_a.size(), NLOAD);
    for (int i = 0; i < NLOAD && i < wq_a.size(); i++) begin
      check_val("load_addr", wq_a[i], tbl_a[i]);
      check_val("load_data", wq_d[i], tbl_d[i]);
    end
  endtask

  task automatic reset_abort(input bit in_check);
    int n;
    setup_table(32'd85, 1'b0, 1'b0, 1'b0);
    halt_at = in_check ? 3 : 1000;
    stale_halt = 1'b0;
    @(negedge clk1); start = 1'b1;
    @(negedge clk1); start = 1'b0;
    n = 0;
    while (!bus.core_run && n < 50) begin @(negedge clk1); n++; end
    check_val("reach_run", bus.core_run, 1'b1);
    if (in_check) begin
      n = 0;
      while (bus.core_run && n < 50) begin @(negedge clk1); n++; end
      check_val("reach_check", {busy, bus.core_run}, 2'b10);
    end else begin
      repeat (2) @(negedge clk1);
    end
    #2 reset = 1'b1;
    #1 check_reset_outputs(in_check ? "abort_check" : "abort_run");
    @(negedge clk1); reset = 1'b0;
    $display("[TB] reset abort during %s", in_check ? "CHECK" : "RUN");
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    setup_table(32'd85, 1'b0, 1'b0, 1'b0);
    #13 check_reset_outputs("reset_state");
    @(negedge clk1); reset = 1'b0;

    // Directed: nominal, wrong expected Mem[121], no HLT, stale halt flag
    setup_table(32'd85, 1'b0, 1'b0, 1'b0); run_seq(10, 1'b0, 0);
    setup_table(32'd85, 1'b0, 1'b1, 1'b0); run_seq(10, 1'b0, 0);
    setup_table(32'd85, 1'b0, 1'b0, 1'b1); run_seq(1000, 1'b0, 0);
    setup_table(32'd85, 1'b0, 1'b0, 1'b0); run_seq(5, 1'b1, 0);
    setup_table(32'd85, 1'b0, 1'b0, 1'b0); run_seq(1, 1'b1, 4);
    setup_table(32'd85, 1'b0, 1'b0, 1'b0); run_seq(TIMEOUT - 1, 1'b0, 0);
    setup_table(32'd85, 1'b0, 1'b0, 1'b0); run_seq(TIMEOUT, 1'b0, 20);

    reset_abort(1'b0);
    reset_abort(1'b1);
    setup_table(32'd85, 1'b0, 1'b0, 1'b0); run_seq(10, 1'b0, 0);

    for (int k = 0; k < 20; k++) begin
      int h, poke;
      h = int'($urandom_range(1, 70));
      poke = ($urandom % 2 == 0) ? 0 : int'($urandom_range(2, 9 + ((h < TIMEOUT) ? h + 1 : TIMEOUT)));
      setup_table($urandom, ($urandom % 4) == 0, ($urandom % 3) == 0, 1'b0);
      run_seq(h, 1'($urandom % 2), poke);
    end

    check_val("invariants", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
